// File: rtl/ir_sequencer.sv
// rtl/ir_sequencer.sv - instruction register and step counter closing the decode loop
//
// Holds the instruction register and two-bit step counter that feed the control
// decoder, and acts on the decoder's load/clear/immediate/done controls. Opcode
// and immediate bytes arrive over a valid/ack byte source. A step that needs a
// byte waits while none is offered. A step counter that runs past its last step
// without being cleared is treated as an unknown opcode: it is flagged and the
// instruction register is forced back to the fetch opcode.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   run            1 = execute, 0 = halt at the next instruction boundary
//   data_in        opcode or immediate byte from the byte source
//   data_valid     data_in holds a valid byte
//   data_ack       byte on data_in consumed this cycle (combinational)
//   rIR_enable     decoder: load the instruction register from data_in
//   counter_clear  decoder: return the step counter to 0
//   data_in_select decoder: this step consumes an immediate byte
//   done           decoder: instruction retires on this step
//   rIR_data       instruction register, to decoder
//   counter        step counter, to decoder
//   stall          waiting on the byte source (combinational)
//   illegal        sticky flag, step counter overran without a clear
//   instr_count    retired instruction count, wraps

module ir_sequencer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [7:0]       data_in,
   input  logic             data_valid,
   output logic             data_ack,
   input  logic             rIR_enable,
   input  logic             counter_clear,
   input  logic             data_in_select,
   input  logic             done,
   output logic [7:0]       rIR_data,
   output logic [1:0]       counter,
   output logic             stall,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } stateT;

   stateT stateQ;
   stateT stateD;

   logic needByte;
   logic advance;
   logic overrun;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ <= IDLE;
      end else begin
         stateQ <= stateD;
      end
   end

   // Next state. Halting only happens on a cycle that actually retires an
   // instruction, so the IR already holds the next opcode when IDLE is entered.
   always_comb begin
      stateD = stateQ;
      case (stateQ)
         IDLE: begin
            if (run) begin
               stateD = EXEC;
            end
         end
         EXEC: begin
            if (advance && done && !run) begin
               stateD = IDLE;
            end
         end
         default: stateD = IDLE;
      endcase
   end

   // Outputs. Loading the IR and taking an immediate share the single byte
   // offered per cycle, so at most one ack is raised.
   always_comb begin
      needByte = rIR_enable | data_in_select;
      advance  = 1'b0;
      stall    = 1'b0;
      data_ack = 1'b0;
      if (!reset && stateQ == EXEC) begin
         advance  = !needByte || data_valid;
         stall    = needByte && !data_valid;
         data_ack = needByte && data_valid;
      end
   end

   // A step past 3 without a clear means the decoder fell into its default case.
   assign overrun = (counter == 2'd3) && !counter_clear;

   always_ff @(posedge clk) begin
      if (reset) begin
         rIR_data    <= 8'h00;
         counter     <= 2'd0;
         illegal     <= 1'b0;
         instr_count <= '0;
      end else if (advance) begin
         if (overrun) begin
            // IR = 00h with counter 0 makes the decoder request a fresh fetch.
            illegal  <= 1'b1;
            rIR_data <= 8'h00;
            counter  <= 2'd0;
         end else begin
            if (rIR_enable) begin
               rIR_data <= data_in;
            end
            counter <= counter_clear ? 2'd0 : counter + 2'd1;
         end
         if (done) begin
            instr_count <= instr_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ir_sequencer.sv
// tb/tb_ir_sequencer.sv - self-checking bench for ir_sequencer with a small decoder and reference model

module tb_ir_sequencer;

   logic       clk;
   logic       reset;
   logic       run;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ack;
   logic       rIR_enable;
   logic       counter_clear;
   logic       data_in_select;
   logic       done;
   logic [7:0] rIR_data;
   logic [1:0] counter;
   logic       stall;
   logic       illegal;
   logic [7:0] instr_count;

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [7:0] mIR;
   int         mCnt;
   logic       mIll;
   int         mCount;
   logic       mRun;

   // Last sampled combinational outputs, for directed literal checks
   logic sAck;
   logic sStall;

   ir_sequencer #(.CNT_W(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .run           (run),
      .data_in       (data_in),
      .data_valid    (data_valid),
      .data_ack      (data_ack),
      .rIR_enable    (rIR_enable),
      .counter_clear (counter_clear),
      .data_in_select(data_in_select),
      .done          (done),
      .rIR_data      (rIR_data),
      .counter       (counter),
      .stall         (stall),
      .illegal       (illegal),
      .instr_count   (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Toy decoder: {load IR, clear counter, immediate, done}
   //   00h fetch, 78h MOV (1 step), 3Eh MOVI (imm + 1 step), 06h (3 steps), others unknown.
   function automatic logic [3:0] decode(input logic [7:0] ir, input logic [1:0] c);
      logic [3:0] r;
      r = 4'b0000;
      case (ir)
         8'h00: if (c == 2'd0) r = 4'b1100;
         8'h78: if (c == 2'd0) r = 4'b1101;
         8'h3E: begin
            if (c == 2'd0) r = 4'b0010;
            else if (c == 2'd1) r = 4'b1101;
         end
         8'h06: if (c == 2'd2) r = 4'b1101;
         default: r = 4'b0000;
      endcase
      return r;
   endfunction

   always_comb begin
      {rIR_enable, counter_clear, data_in_select, done} = decode(rIR_data, counter);
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check combinational outputs, advance the
   // model, then check the registered outputs after the edge.
   task automatic step(input logic rst, input logic r, input logic v, input logic [7:0] d);
      logic [3:0] dec;
      logic       need;
      logic       expAck;
      logic       expStall;
      reset      = rst;
      run        = r;
      data_valid = v;
      data_in    = d;
      #1;
      dec      = decode(mIR, 2'(mCnt));
      need     = dec[3] | dec[1];
      expStall = !rst && mRun && need && !v;
      expAck   = !rst && mRun && need && v;
      sAck     = data_ack;
      sStall   = stall;
      chk("stall", int'(stall), int'(expStall));
      chk("data_ack", int'(data_ack), int'(expAck));

      if (rst) begin
         mIR = 8'h00; mCnt = 0; mIll = 1'b0; mCount = 0; mRun = 1'b0;
      end else if (!mRun) begin
         mRun = r;
      end else if (!(need && !v)) begin
         if (mCnt == 3 && !dec[2]) begin
            mIll = 1'b1;
            mIR  = 8'h00;
            mCnt = 0;
         end else begin
            if (dec[3]) mIR = d;
            mCnt = dec[2] ? 0 : mCnt + 1;
         end
         if (dec[0]) mCount = (mCount + 1) % 256;
         if (!r && dec[0]) mRun = 1'b0;
      end

      @(posedge clk);
      @(negedge clk);
      chk("rIR_data", int'(rIR_data), int'(mIR));
      chk("counter", int'(counter), mCnt);
      chk("illegal", int'(illegal), int'(mIll));
      chk("instr_count", int'(instr_count), mCount);
   endtask

   function automatic logic [7:0] pickByte();
      case ($urandom_range(0, 9))
         0, 1, 2: return 8'h78;
         3, 4, 5: return 8'h3E;
         6, 7:    return 8'h06;
         8:       return 8'hC3;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      reset = 1'b1; run = 1'b0; data_valid = 1'b0; data_in = 8'h00;
      mIR = 8'h00; mCnt = 0; mIll = 1'b0; mCount = 0; mRun = 1'b0;
      sAck = 1'b0; sStall = 1'b0;
      @(negedge clk);

      // Reset values
      step(1'b1, 1'b0, 1'b0, 8'h00);
      chk("lit_reset_ir", int'(rIR_data), 8'h00);
      chk("lit_reset_cnt", int'(counter), 0);
      chk("lit_reset_count", int'(instr_count), 0);

      // IDLE -> EXEC, no byte taken
      step(1'b0, 1'b1, 1'b1, 8'h78);
      chk("lit_idle_ack", int'(sAck), 0);
      // Fetch MOV
      step(1'b0, 1'b1, 1'b1, 8'h78);
      chk("lit_fetch_ack", int'(sAck), 1);
      chk("lit_fetch_ir", int'(rIR_data), 8'h78);
      chk("lit_fetch_cnt", int'(counter), 0);
      // MOV retires, fetch MOVI
      step(1'b0, 1'b1, 1'b1, 8'h3E);
      chk("lit_mov_count", int'(instr_count), 1);
      chk("lit_movi_ir", int'(rIR_data), 8'h3E);
      // MOVI immediate
      step(1'b0, 1'b1, 1'b1, 8'h5A);
      chk("lit_imm_ack", int'(sAck), 1);
      chk("lit_imm_cnt", int'(counter), 1);
      // MOVI retires, fetch unknown C3h
      step(1'b0, 1'b1, 1'b1, 8'hC3);
      chk("lit_movi_count", int'(instr_count), 2);
      chk("lit_c3_ir", int'(rIR_data), 8'hC3);
      // Unknown opcode walks 1,2,3 then overruns
      step(1'b0, 1'b1, 1'b1, 8'h11);
      chk("lit_ill_c1", int'(counter), 1);
      step(1'b0, 1'b1, 1'b1, 8'h11);
      chk("lit_ill_c2", int'(counter), 2);
      step(1'b0, 1'b1, 1'b1, 8'h11);
      chk("lit_ill_c3", int'(counter), 3);
      chk("lit_ill_before", int'(illegal), 0);
      step(1'b0, 1'b1, 1'b1, 8'h11);
      chk("lit_ill_set", int'(illegal), 1);
      chk("lit_ill_ir", int'(rIR_data), 8'h00);
      chk("lit_ill_cnt", int'(counter), 0);
      // Refetch MOVI, illegal stays set
      step(1'b0, 1'b1, 1'b1, 8'h3E);
      chk("lit_refetch_ir", int'(rIR_data), 8'h3E);
      chk("lit_ill_sticky", int'(illegal), 1);
      // Stall 3 cycles on the immediate
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'(8'hA0 + i));
         chk("lit_stall", int'(sStall), 1);
         chk("lit_stall_cnt", int'(counter), 0);
      end
      step(1'b0, 1'b1, 1'b1, 8'h5A);
      chk("lit_unstall_cnt", int'(counter), 1);
      // MOVI retires, fetch MOVI for the halt case
      step(1'b0, 1'b1, 1'b1, 8'h3E);
      // run dropped during step 0: instruction still completes
      step(1'b0, 1'b0, 1'b1, 8'h5A);
      step(1'b0, 1'b0, 1'b1, 8'h78);
      chk("lit_halt_ir", int'(rIR_data), 8'h78);
      chk("lit_halt_cnt", int'(counter), 0);
      chk("lit_halt_count", int'(instr_count), 4);
      step(1'b0, 1'b0, 1'b1, 8'h3E);
      chk("lit_halt_ack", int'(sAck), 0);
      chk("lit_halt_hold", int'(rIR_data), 8'h78);
      // Resume
      step(1'b0, 1'b1, 1'b1, 8'h3E);
      step(1'b0, 1'b1, 1'b1, 8'h3E);
      chk("lit_resume_count", int'(instr_count), 5);
      // Stall then reset mid-stall
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("lit_stall2", int'(sStall), 1);
      step(1'b1, 1'b1, 1'b0, 8'h00);
      chk("lit_rst_stall", int'(sStall), 0);
      chk("lit_rst_ack", int'(sAck), 0);
      chk("lit_rst_count", int'(instr_count), 0);
      chk("lit_rst_ill", int'(illegal), 0);
      chk("lit_rst_ir", int'(rIR_data), 8'h00);

      // Randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         step($urandom_range(0, 299) == 0,
              $urandom_range(0, 7) != 0,
              $urandom_range(0, 3) != 0,
              pickByte());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
